execute_muldiv_unit: RTL and testbench
======================================

// Module: execute_muldiv_unit
// PURPOSE
//  Iterative multiply/divide companion to the single-cycle execute stage. Owns the HI/LO
//  registers and runs mult, multu, div and divu as a multi-cycle operation. The control
//  unit stalls the fetch stage while busy is high.
//  Generalised in width.
//  The divider is optional and is selected by macro.
// PARAMETERS
//  DATA_W  32  operand, HI and LO width; must be >= 2
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  clock     in   1       rising-edge clock
//  reset     in   1       synchronous, active-high
//  start     in   1       request; sampled only in IDLE
//  op        in   2       00 mult, 01 multu, 10 div, 11 divu
//  Ainput    in   DATA_W  rs: multiplicand or dividend
//  Binput    in   DATA_W  rt: multiplier or divisor
//  hi_we     in   1       mthi write strobe
//  lo_we     in   1       mtlo write strobe
//  wdata     in   DATA_W  mthi/mtlo data
//  busy      out  1       high whenever state != IDLE
//  done      out  1       one-cycle pulse; HI/LO valid in the same cycle
//  div_zero  out  1       pulses together with done for a divide by zero
//  hi        out  DATA_W  HI register
//  lo        out  DATA_W  LO register
// BEHAVIOUR
//  Reset (any state, including mid-operation):
//  - state goes to IDLE; hi, lo, busy, done, div_zero all go to 0; the operation is dropped.
//  FSM states: IDLE, MUL, DIV, FIX, DONE.
//  - IDLE + start + op[1]=0 -> MUL.
//  - IDLE + start + op[1]=1, Binput!=0 -> DIV.
//  - IDLE + start + op[1]=1, Binput==0 -> DONE (divide-by-zero path).
//  - MUL/DIV -> FIX after exactly DATA_W iteration cycles.
//  - FIX -> DONE; DONE -> IDLE.
//  Operand capture at start:
//  - Signed ops (op[0]=0) capture absolute values and record the sign bits.
//  - Unsigned ops capture the raw values.
//  Iteration: one bit per cycle; the counter loads DATA_W-1 and the state exits when it reaches 0.
//  - MUL: shift-add. The 2*DATA_W product is built in an internal accumulator.
//  - DIV: restoring shift-subtract over a DATA_W+1-bit partial remainder.
//  FIX cycle:
//  - Signed mult: negate the product if the operand signs differ.
//  - Signed div: negate the quotient if the signs differ; the remainder takes the dividend's sign.
//  - Writes HI/LO: HI = upper half / remainder, LO = lower half / quotient.
//  Latency: start sampled at edge 0 -> done high in cycle DATA_W+2; busy high in cycles 1..DATA_W+2.
//  Divide by zero: done and div_zero high in cycle 1; LO = all ones; HI = Ainput (raw).
//  Signed MIN / -1: LO = MIN, HI = 0 (two's complement wrap); no flag.
//  start while busy: ignored; no queueing.
//  hi_we / lo_we:
//  - Honoured only in IDLE with start=0; the write is visible next cycle.
//  - Ignored while busy or when start is high in the same cycle (start wins).
//  - hi_we and lo_we together write both registers from wdata.
//  done and div_zero are registered outputs; never high outside DONE.
// CONFIGURATION
//  EXE_MULDIV_DIV_EN defined: divider datapath, DIV state and signed-divide fixup are built as above.
//  EXE_MULDIV_DIV_EN undefined: DIV state and divider are not built.
//  - Any start with op[1]=1 goes IDLE -> DONE in one cycle.
//  - div_zero=1; HI/LO unchanged.
//  - Multiply behaviour and latency are identical in both builds.
// TESTING (DATA_W=32)
//  T1 mult A=7, B=FFFFFFFD (-3):
//     -> busy high cycles 1..34, done cycle 34, HI=FFFFFFFF, LO=FFFFFFEB.
//  T2 multu A=B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001, div_zero=0.
//  T3 div A=FFFFFFF9 (-7), B=2 -> LO=FFFFFFFD, HI=FFFFFFFF; divu same operands -> LO=7FFFFFFC, HI=1.
//  T4 divu A=64, B=0 -> done and div_zero in cycle 1, LO=FFFFFFFF, HI=00000064.
//     Without EXE_MULDIV_DIV_EN: HI/LO keep their prior values.
//  T5 reset asserted in cycle 10 of a mult -> next cycle busy=0, hi=lo=0; no done pulse follows.
//  T6 start pulse and hi_we(wdata=AA) while busy -> HI unchanged, one done only.
//     In IDLE: hi_we(wdata=AA) -> hi=AA next cycle.
//     start + lo_we together in IDLE -> op runs, write dropped.

Source files
------------

// File: rtl/execute_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : execute_muldiv_unit
// Brief    : Iterative mult/multu/div/divu unit owning HI/LO; the restoring
//            divider is built only when EXE_MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module execute_muldiv_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] Ainput,
   input  logic [DATA_W-1:0] Binput,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_MUL  = 3'd1;
   localparam logic [2:0] c_FIX  = 3'd3;
   localparam logic [2:0] c_DONE = 3'd4;
`ifdef EXE_MULDIV_DIV_EN
   localparam logic [2:0] c_DIV  = 3'd2;
`endif

   logic [2:0]          r_state;
   logic [CNT_W-1:0]    r_cnt;
   // MUL: {partial product, remaining multiplier}; DIV: low half holds dividend/quotient
   logic [2*DATA_W-1:0] r_acc;
   logic [DATA_W-1:0]   r_mcand;
   logic                r_neg_res;
   logic                r_done;
   logic                r_div_zero;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;

   logic                w_a_neg;
   logic                w_b_neg;
   logic [DATA_W-1:0]   w_a_abs;
   logic [DATA_W-1:0]   w_b_abs;
   logic [DATA_W:0]     w_sum;
   logic [2*DATA_W-1:0] w_prod;
   logic [DATA_W-1:0]   w_fix_hi;
   logic [DATA_W-1:0]   w_fix_lo;

   assign w_a_neg = ~op[0] & Ainput[DATA_W-1];
   assign w_b_neg = ~op[0] & Binput[DATA_W-1];
   assign w_a_abs = w_a_neg ? -Ainput : Ainput;
   assign w_b_abs = w_b_neg ? -Binput : Binput;
   assign w_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_prod  = r_neg_res ? -r_acc : r_acc;

`ifdef EXE_MULDIV_DIV_EN
   logic [DATA_W-1:0]   r_rem;
   logic                r_neg_rem;
   logic                r_is_div;
   logic [DATA_W:0]     w_shift;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W-1:0]   w_quo;
   logic [DATA_W-1:0]   w_rem;

   // Remainder stays below the divisor, so DATA_W bits hold it between steps
   assign w_shift  = {r_rem, r_acc[DATA_W-1]};
   assign w_diff   = w_shift - {1'b0, r_mcand};
   assign w_quo    = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
   assign w_rem    = r_neg_rem ? -r_rem : r_rem;
   assign w_fix_hi = r_is_div ? w_rem : w_prod[2*DATA_W-1:DATA_W];
   assign w_fix_lo = r_is_div ? w_quo : w_prod[DATA_W-1:0];
`else
   assign w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
   assign w_fix_lo = w_prod[DATA_W-1:0];
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_neg_res  <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
`ifdef EXE_MULDIV_DIV_EN
         r_rem      <= '0;
         r_neg_rem  <= 1'b0;
         r_is_div   <= 1'b0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_cnt     <= CNT_W'(DATA_W - 1);
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  if (op[1]) begin
`ifdef EXE_MULDIV_DIV_EN
                     r_is_div  <= 1'b1;
                     r_neg_rem <= w_a_neg;
                     r_acc     <= {{DATA_W{1'b0}}, w_a_abs};
                     r_rem     <= '0;
                     r_mcand   <= w_b_abs;
                     if (Binput == '0) begin
                        r_state    <= c_DONE;
                        r_done     <= 1'b1;
                        r_div_zero <= 1'b1;
                        r_hi       <= Ainput;
                        r_lo       <= '1;
                     end else begin
                        r_state    <= c_DIV;
                     end
`else
                     r_state    <= c_DONE;
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
`endif
                  end else begin
`ifdef EXE_MULDIV_DIV_EN
                     r_is_div <= 1'b0;
`endif
                     r_state  <= c_MUL;
                     r_acc    <= {{DATA_W{1'b0}}, w_b_abs};
                     r_mcand  <= w_a_abs;
                  end
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            c_MUL: begin
               r_acc <= {w_sum, r_acc[DATA_W-1:1]};
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == '0) r_state <= c_FIX;
            end
`ifdef EXE_MULDIV_DIV_EN
            c_DIV: begin
               r_acc[DATA_W-1:0] <= {r_acc[DATA_W-2:0], ~w_diff[DATA_W]};
               r_rem <= w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == '0) r_state <= c_FIX;
            end
`endif
            c_FIX: begin
               r_hi    <= w_fix_hi;
               r_lo    <= w_fix_lo;
               r_done  <= 1'b1;
               r_state <= c_DONE;
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign busy     = (r_state != c_IDLE);
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_muldiv_unit
// Brief    : Directed self-checking bench for execute_muldiv_unit (DATA_W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv_unit;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset, start, hi_we, lo_we;
   logic [1:0]   op;
   logic [W-1:0] Ainput, Binput, wdata;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   int           n_busy, n_done, done_cyc;
   logic [W-1:0] d_hi, d_lo;
   logic         d_dz;

   always #5 clock = ~clock;

   execute_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .Ainput(Ainput), .Binput(Binput), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Leaves the bench at the negedge of cycle 1 of the operation
   task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      op = o; Ainput = a; Binput = b; start = 1'b1;
      step();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
   endtask

   task automatic watch(input int n);
      n_busy = 0; n_done = 0; done_cyc = 0; d_hi = '0; d_lo = '0; d_dz = 1'b0;
      for (int c = 1; c <= n; c++) begin
         if (busy) n_busy++;
         if (done) begin
            n_done++; done_cyc = c; d_hi = hi; d_lo = lo; d_dz = div_zero;
         end
         step();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'b00; Ainput = '0; Binput = '0; wdata = '0;
      step(); step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz",   div_zero, 0);
      check("rst_hi",   hi, 0);
      check("rst_lo",   lo, 0);
      reset = 1'b0;

      // T1 mult 7 * -3
      launch(2'b00, 32'd7, 32'hFFFFFFFD);
      watch(40);
      check("t1_busy_cycles", n_busy, 34);
      check("t1_done_cycle",  done_cyc, 34);
      check("t1_done_count",  n_done, 1);
      check("t1_hi", d_hi, 32'hFFFFFFFF);
      check("t1_lo", d_lo, 32'hFFFFFFEB);
      check("t1_dz", d_dz, 0);
      check("t1_idle", busy, 0);

      // T2 multu max * max
      launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      watch(40);
      check("t2_done_cycle", done_cyc, 34);
      check("t2_hi", d_hi, 32'hFFFFFFFE);
      check("t2_lo", d_lo, 32'h00000001);
      check("t2_dz", d_dz, 0);

      // T3 div -7 / 2, then divu same operands, then MIN / -1
      launch(2'b10, 32'hFFFFFFF9, 32'd2);
      watch(40);
`ifdef EXE_MULDIV_DIV_EN
      check("t3_div_cycle", done_cyc, 34);
      check("t3_div_dz",    d_dz, 0);
      check("t3_div_lo",    lo, 32'hFFFFFFFD);
      check("t3_div_hi",    hi, 32'hFFFFFFFF);
`else
      check("t3_div_cycle", done_cyc, 1);
      check("t3_div_dz",    d_dz, 1);
      check("t3_div_lo",    lo, 32'h00000001);
      check("t3_div_hi",    hi, 32'hFFFFFFFE);
`endif
      launch(2'b11, 32'hFFFFFFF9, 32'd2);
      watch(40);
`ifdef EXE_MULDIV_DIV_EN
      check("t3_divu_cycle", done_cyc, 34);
      check("t3_divu_lo",    lo, 32'h7FFFFFFC);
      check("t3_divu_hi",    hi, 32'h00000001);
`else
      check("t3_divu_cycle", done_cyc, 1);
      check("t3_divu_lo",    lo, 32'h00000001);
      check("t3_divu_hi",    hi, 32'hFFFFFFFE);
`endif
      launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
      watch(40);
`ifdef EXE_MULDIV_DIV_EN
      check("t3_minneg_dz", d_dz, 0);
      check("t3_minneg_lo", lo, 32'h80000000);
      check("t3_minneg_hi", hi, 32'h00000000);
`else
      check("t3_minneg_dz", d_dz, 1);
      check("t3_minneg_lo", lo, 32'h00000001);
`endif

      // T4 divu by zero
      launch(2'b11, 32'h64, 32'd0);
      watch(5);
      check("t4_done_cycle", done_cyc, 1);
      check("t4_dz",         d_dz, 1);
      check("t4_busy_cycles", n_busy, 1);
`ifdef EXE_MULDIV_DIV_EN
      check("t4_lo", lo, 32'hFFFFFFFF);
      check("t4_hi", hi, 32'h00000064);
`else
      check("t4_lo", lo, 32'h00000001);
      check("t4_hi", hi, 32'hFFFFFFFE);
`endif

      // T5 reset in cycle 10 of a mult
      launch(2'b00, 32'd9, 32'd9);
      for (int i = 0; i < 9; i++) step();
      check("t5_busy_c10", busy, 1);
      reset = 1'b1;
      step();
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_hi",   hi, 0);
      check("t5_lo",   lo, 0);
      reset = 1'b0;
      watch(40);
      check("t5_no_done", n_done, 0);
      check("t5_no_busy", n_busy, 0);

      // T6 start and hi_we while busy are ignored
      launch(2'b00, 32'hFFFFFFFF, 32'd2);
      for (int i = 0; i < 4; i++) step();
      op = 2'b00; start = 1'b1; hi_we = 1'b1; wdata = 32'hAA;
      step();
      start = 1'b0; hi_we = 1'b0;
      watch(40);
      check("t6_done_count", n_done, 1);
      check("t6_done_cycle", done_cyc, 29);
      check("t6_hi", hi, 32'hFFFFFFFF);
      check("t6_lo", lo, 32'hFFFFFFFE);

      hi_we = 1'b1; wdata = 32'hAA;
      step();
      hi_we = 1'b0;
      check("t6_mthi_hi", hi, 32'hAA);
      check("t6_mthi_lo", lo, 32'hFFFFFFFE);

      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
      step();
      hi_we = 1'b0; lo_we = 1'b0;
      check("t6_both_hi", hi, 32'h55);
      check("t6_both_lo", lo, 32'h55);

      lo_we = 1'b1; wdata = 32'h123;
      launch(2'b01, 32'd3, 32'd4);
      watch(40);
      check("t6_start_wins_cycle", done_cyc, 34);
      check("t6_start_wins_lo", lo, 32'd12);
      check("t6_start_wins_hi", hi, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
